ysyx_23060025_rd_xbar: RTL
==========================

YSYX_23060025_RD_XBAR -- requirements
Module: ysyx_23060025_rd_xbar

Interface
REQ-001 The block SHALL have one clock `clock` and an asynchronous, active-low reset `rstn`.
REQ-002 Parameter ADDR_LEN, 32, address width.
REQ-003 Parameter DATA_LEN, 32, data width.
REQ-004 Parameter MEM_BASE, 32'h8000_0000, first byte of the main-memory window.
REQ-005 Parameter MEM_END, 32'h87FF_FFFF, last byte of the main-memory window, inclusive.
REQ-006 Parameter CLINT_BASE, 32'h0200_0000, first byte of the CLINT window.
REQ-007 Parameter CLINT_END, 32'h0200_FFFF, last byte of the CLINT window, inclusive.
REQ-008 Port list (name  direction  width  meaning):
- clock  in  1  clock
- rstn  in  1  async active-low reset
- m_ar_addr  in  ADDR_LEN  master read address
- m_ar_valid  in  1  master address valid
- m_ar_ready  out  1  xbar accepts address
- m_r_data  out  DATA_LEN  read data to master
- m_r_resp  out  2  response to master (00 OKAY, 11 DECERR)
- m_r_valid  out  1  read data valid
- m_r_ready  in  1  master accepts data
- s0_ar_addr / s0_ar_valid  out  ADDR_LEN / 1  memory slave address channel
- s0_ar_ready  in  1  memory slave address ready
- s0_r_data / s0_r_resp / s0_r_valid  in  DATA_LEN / 2 / 1  memory slave data channel
- s0_r_ready  out  1  memory slave data ready
- s1_ar_addr / s1_ar_valid / s1_ar_ready / s1_r_data / s1_r_resp / s1_r_valid / s1_r_ready: the same set for the CLINT slave.

Function
REQ-009 The FSM SHALL have four states: IDLE, REQ, RESP and ERR.
REQ-010 IDLE: m_ar_ready = 1. When m_ar_valid = 1:
- latch m_ar_addr into addr_q;
- latch the decoded target into sel_q;
- go to REQ if the address is mapped, or to ERR if it is unmapped.
REQ-011 Address decode:
- CLINT when CLINT_BASE <= addr <= CLINT_END;
- otherwise memory when MEM_BASE <= addr <= MEM_END;
- otherwise unmapped.
- If the windows overlap, CLINT wins.
REQ-012 REQ:
- drive addr_q and ar_valid = 1 to the slave selected by sel_q only;
- m_ar_ready = 0;
- on the selected slave's ar_ready = 1, go to RESP.
- ar_valid stays asserted and addr_q stays stable until the handshake.
REQ-013 RESP:
- m_r_data, m_r_resp and m_r_valid pass combinationally from the selected slave;
- the selected slave's r_ready equals m_r_ready;
- on m_r_valid & m_r_ready, go to IDLE.
REQ-014 ERR:
- m_r_valid = 1, m_r_data = 0, m_r_resp = 2'b11;
- no slave is driven;
- on m_r_ready, go to IDLE.
REQ-015 Outside RESP/ERR, m_r_valid = 0, m_r_data = 0 and m_r_resp = 2'b00.
REQ-016 The unselected slave SHALL see ar_valid = 0, r_ready = 0 and ar_addr = 0 in every state.
REQ-017 r_valid from the unselected slave, or any r_valid outside RESP, SHALL be ignored and never reach the master.
REQ-018 Minimum latency: address accepted in cycle N; slave ar_valid in N+1; master data in the same cycle as the slave's r_valid.
REQ-019 One outstanding transaction at most; a new address is accepted only in IDLE, including the cycle after a completed response.
REQ-020 If the slave asserts ar_ready before entering REQ, it has no effect; only an ar_ready sampled in REQ advances the FSM.
REQ-021 Upper-boundary addresses (e.g. CLINT_END, MEM_END) SHALL be mapped; END+1 SHALL be unmapped unless it falls in the other window.

Reset
REQ-022 When rstn = 0, asynchronously:
- the FSM returns to IDLE;
- addr_q = 0 and sel_q = memory;
- all valid/ready outputs = 0, except that m_ar_ready follows IDLE and rstn (0 while in reset);
- data/resp outputs = 0.
REQ-023 Reset asserted mid-transaction (REQ or RESP) SHALL abort with no response to the master. After release, the first accepted address SHALL be routed correctly.

Verification
REQ-024 Read 0x0200_0000 (CLINT slave: ar_ready=1, r_valid 1 cycle later with data 0x0000_0123, resp 00) -> s1_ar_valid in N+1, m_r_data = 0x0000_0123, m_r_resp = 00, s0 never valid.
REQ-025 Read 0x8000_0010 (memory slave with 3-cycle ar_ready delay, data 0xDEAD_BEEF) -> s0_ar_addr held at 0x8000_0010 through the delay, m_r_data = 0xDEAD_BEEF.
REQ-026 Read 0x1000_0000 -> ERR: m_r_valid=1, m_r_resp = 11, m_r_data = 0; with m_r_ready held low for 4 cycles the response persists; no slave valid.
REQ-027 Boundary reads:
- 0x0200_FFFF -> CLINT;
- 0x0201_0000 -> DECERR;
- 0x87FF_FFFF -> memory;
- 0x8800_0000 -> DECERR.
REQ-028 Back-pressure: with m_r_ready low for 5 cycles in RESP, s0_r_ready stays 0 and the data is held; with a spurious s1_r_valid=1 during a memory read, the master output is unchanged.
REQ-029 Reset mid-transaction: rstn pulled low while in RESP -> all outputs go to 0 immediately, asynchronous to clock; after release, a read of 0x0200_0004 completes with CLINT data.

Source files
------------

// File: rtl/ysyx_23060025_rd_xbar.sv
// ----------------------------------------------------------------------------
// ysyx_23060025_rd_xbar
//
// Read-only crossbar from one master to two slaves: main memory (s0) and the
// CLINT (s1). Each transaction is decoded on acceptance and routed to one
// slave. Unmapped addresses complete locally with a DECERR. At most one
// transaction can be in flight at a time.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. valid is never withdrawn before that edge, and payload
// (addr/data/resp) stays stable while valid is 1 and ready is 0.
//
// Ports
//   clock, rstn          clock and asynchronous active-low reset
//   m_ar_*               master read-address channel (xbar is the sink)
//   m_r_*                master read-data channel (xbar is the source)
//   s0_ar_*, s0_r_*      memory slave channels (xbar is the master)
//   s1_ar_*, s1_r_*      CLINT slave channels (xbar is the master)
//   dbg_state            current FSM state, for checkers and debug
// ----------------------------------------------------------------------------
module ysyx_23060025_rd_xbar #(
  parameter int                  ADDR_LEN   = 32,
  parameter int                  DATA_LEN   = 32,
  parameter logic [ADDR_LEN-1:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [ADDR_LEN-1:0] MEM_END    = 32'h87FF_FFFF,
  parameter logic [ADDR_LEN-1:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [ADDR_LEN-1:0] CLINT_END  = 32'h0200_FFFF
) (
  input  logic                clock,
  input  logic                rstn,
  // master
  input  logic [ADDR_LEN-1:0] m_ar_addr,
  input  logic                m_ar_valid,
  output logic                m_ar_ready,
  output logic [DATA_LEN-1:0] m_r_data,
  output logic [1:0]          m_r_resp,
  output logic                m_r_valid,
  input  logic                m_r_ready,
  // memory slave
  output logic [ADDR_LEN-1:0] s0_ar_addr,
  output logic                s0_ar_valid,
  input  logic                s0_ar_ready,
  input  logic [DATA_LEN-1:0] s0_r_data,
  input  logic [1:0]          s0_r_resp,
  input  logic                s0_r_valid,
  output logic                s0_r_ready,
  // CLINT slave
  output logic [ADDR_LEN-1:0] s1_ar_addr,
  output logic                s1_ar_valid,
  input  logic                s1_ar_ready,
  input  logic [DATA_LEN-1:0] s1_r_data,
  input  logic [1:0]          s1_r_resp,
  input  logic                s1_r_valid,
  output logic                s1_r_ready,
  // debug
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  // sel_q encoding: 0 = memory, 1 = CLINT
  localparam logic SEL_MEM   = 1'b0;
  localparam logic SEL_CLINT = 1'b1;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [ADDR_LEN-1:0] addr_q;
  logic                sel_q;

  // Decode of the incoming address. CLINT is tested first so it wins if the
  // two windows are ever configured to overlap.
  logic hit_clint;
  logic hit_mem;
  logic dec_sel;
  logic dec_mapped;

  always_comb begin
    hit_clint  = (m_ar_addr >= CLINT_BASE) && (m_ar_addr <= CLINT_END);
    hit_mem    = (m_ar_addr >= MEM_BASE) && (m_ar_addr <= MEM_END);
    dec_sel    = hit_clint ? SEL_CLINT : SEL_MEM;
    dec_mapped = hit_clint || hit_mem;
  end

  // Signals from the currently selected slave.
  logic                sel_ar_ready;
  logic                sel_r_valid;
  logic [DATA_LEN-1:0] sel_r_data;
  logic [1:0]          sel_r_resp;

  always_comb begin
    sel_ar_ready = (sel_q == SEL_CLINT) ? s1_ar_ready : s0_ar_ready;
    sel_r_valid  = (sel_q == SEL_CLINT) ? s1_r_valid  : s0_r_valid;
    sel_r_data   = (sel_q == SEL_CLINT) ? s1_r_data   : s0_r_data;
    sel_r_resp   = (sel_q == SEL_CLINT) ? s1_r_resp   : s0_r_resp;
  end

  // Next-state logic. Slave ar_ready is only looked at in REQ, so a slave
  // that raises ready early cannot skip the address phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (m_ar_valid) state_d = dec_mapped ? REQ : ERR;
      REQ:  if (sel_ar_ready) state_d = RESP;
      RESP: if (sel_r_valid && m_r_ready) state_d = IDLE;
      ERR:  if (m_r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sel_q   <= SEL_MEM;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && m_ar_valid) begin
        addr_q <= m_ar_addr;
        sel_q  <= dec_sel;
      end
    end
  end

  // Master side. m_ar_ready is gated with rstn so it reads 0 while reset is
  // held even though the state register already sits in IDLE.
  always_comb begin
    m_ar_ready = rstn && (state_q == IDLE);
    m_r_valid  = 1'b0;
    m_r_data   = '0;
    m_r_resp   = 2'b00;
    case (state_q)
      RESP: begin
        m_r_valid = sel_r_valid;
        m_r_data  = sel_r_data;
        m_r_resp  = sel_r_resp;
      end
      ERR: begin
        m_r_valid = 1'b1;
        m_r_resp  = 2'b11;
      end
      default: ;
    endcase
  end

  // Slave side. Only the selected slave ever sees anything non-zero.
  always_comb begin
    s0_ar_valid = (state_q == REQ)  && (sel_q == SEL_MEM);
    s1_ar_valid = (state_q == REQ)  && (sel_q == SEL_CLINT);
    s0_ar_addr  = s0_ar_valid ? addr_q : '0;
    s1_ar_addr  = s1_ar_valid ? addr_q : '0;
    s0_r_ready  = (state_q == RESP) && (sel_q == SEL_MEM)   && m_r_ready;
    s1_r_ready  = (state_q == RESP) && (sel_q == SEL_CLINT) && m_r_ready;
  end

  assign dbg_state = state_q;

endmodule
